// File: rtl/gray_fifo_ctrl_if.sv
// gray_fifo_ctrl_if: request/flag bundle between the FIFO pointer controller
// and its producer/consumer logic.
//   wr_req/rd_req        : requests from producer/consumer
//   wr_ack/rd_ack        : request accepted this cycle
//   wr_addr/rd_addr      : RAM addresses (AW bits)
//   wptr_gray/rptr_gray  : registered Gray pointers (AW+1 bits)
//   full/empty/count     : registered occupancy flags
//   ovf/udf              : one-cycle error pulses
interface gray_fifo_ctrl_if #(
    parameter int AW = 4
);
    logic          wr_req;
    logic          rd_req;
    logic          wr_ack;
    logic          rd_ack;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   wptr_gray;
    logic [AW:0]   rptr_gray;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;

    // producer/consumer side
    modport master (
        output wr_req, rd_req,
        input  wr_ack, rd_ack, wr_addr, rd_addr, wptr_gray, rptr_gray,
               full, empty, count, ovf, udf
    );

    // controller side
    modport slave (
        input  wr_req, rd_req,
        output wr_ack, rd_ack, wr_addr, rd_addr, wptr_gray, rptr_gray,
               full, empty, count, ovf, udf
    );
endinterface

// File: rtl/gray_fifo_ctrl.sv
// gray_fifo_ctrl: single-clock FIFO pointer controller. Keeps AW+1 bit binary
// write/read pointers (MSB = wrap bit) plus registered Gray copies, accepts or
// rejects requests, and produces registered full/empty/count and ovf/udf pulses.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : gray_fifo_ctrl_if.slave (requests in, acks/addresses/flags out)
module gray_fifo_ctrl #(
    parameter int AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    gray_fifo_ctrl_if.slave  bus
);
    logic [AW:0] wptr_bin, rptr_bin;
    logic [AW:0] wptr_bin_n, rptr_bin_n;
    logic [AW:0] wgray_n, rgray_n;
    logic [AW:0] wgray_q, rgray_q;
    logic [AW:0] count_q, count_n;
    logic        full_q, empty_q, full_n, empty_n;
    logic        ovf_q, udf_q;
    logic        wr_ack, rd_ack;

    // Acks look only at registered flags, so there is no combinational path
    // from the pointers back into the accept decision. A cycle with rst high
    // accepts nothing: reset overrides any request.
    assign wr_ack = bus.wr_req & ~full_q  & ~rst;
    assign rd_ack = bus.rd_req & ~empty_q & ~rst;

    assign wptr_bin_n = wptr_bin + {{AW{1'b0}}, wr_ack};
    assign rptr_bin_n = rptr_bin + {{AW{1'b0}}, rd_ack};

    assign wgray_n = wptr_bin_n ^ (wptr_bin_n >> 1);
    assign rgray_n = rptr_bin_n ^ (rptr_bin_n >> 1);

    // In Gray code, "write pointer exactly one lap ahead" means the top two
    // bits are inverted and the rest equal.
    assign empty_n = (wgray_n == rgray_n);
    assign full_n  = (wgray_n == {~rgray_n[AW:AW-1], rgray_n[AW-2:0]});
    assign count_n = wptr_bin_n - rptr_bin_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_bin <= '0;
            rptr_bin <= '0;
            wgray_q  <= '0;
            rgray_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_bin <= wptr_bin_n;
            rptr_bin <= rptr_bin_n;
            wgray_q  <= wgray_n;
            rgray_q  <= rgray_n;
            full_q   <= full_n;
            empty_q  <= empty_n;
            count_q  <= count_n;
            ovf_q    <= bus.wr_req & full_q;
            udf_q    <= bus.rd_req & empty_q;
        end
    end

    assign bus.wr_ack    = wr_ack;
    assign bus.rd_ack    = rd_ack;
    assign bus.wr_addr   = wptr_bin[AW-1:0];
    assign bus.rd_addr   = rptr_bin[AW-1:0];
    assign bus.wptr_gray = wgray_q;
    assign bus.rptr_gray = rgray_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.count     = count_q;
    assign bus.ovf       = ovf_q;
    assign bus.udf       = udf_q;
endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// tb_gray_fifo_ctrl: directed + random stimulus for gray_fifo_ctrl (AW=4).
// The driver pushes the expected per-cycle response into a scoreboard queue;
// a monitor on the falling edge pops and compares against the DUT outputs.
module tb_gray_fifo_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_fifo_ctrl_if #(.AW(AW)) bus ();
    gray_fifo_ctrl #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic          wr_ack, rd_ack;
        logic [AW-1:0] wr_addr, rd_addr;
        logic [AW:0]   wgray, rgray, count;
        logic          full, empty, ovf, udf;
        bit            gchk;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    // reference model: occupancy queue of written addresses plus lap counters
    int          m_q[$];
    logic [AW:0] wcnt = '0, rcnt = '0;
    logic        m_ovf = 1'b0, m_udf = 1'b0;
    bit          m_prev_rst = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [AW:0] g2b(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // one clock cycle: drive, record expectation, advance model, step clock
    task automatic cycle(input bit w, input bit r, input bit rs, input bit push_exp);
        exp_t e;
        bit   wa, ra, ovf_n, udf_n;
        int   sz;
        sz = m_q.size();
        bus.wr_req = w;
        bus.rd_req = r;
        rst        = rs;
        e.wr_ack  = w && !rs && (sz < DEPTH);
        e.rd_ack  = r && !rs && (sz > 0);
        e.wr_addr = wcnt[AW-1:0];
        e.rd_addr = rcnt[AW-1:0];
        e.wgray   = wcnt ^ (wcnt >> 1);
        e.rgray   = rcnt ^ (rcnt >> 1);
        e.count   = sz[AW:0];
        e.full    = (sz == DEPTH);
        e.empty   = (sz == 0);
        e.ovf     = m_ovf;
        e.udf     = m_udf;
        e.gchk    = !m_prev_rst;
        if (push_exp) sb.push_back(e);
        if (rs) begin
            m_q.delete();
            wcnt  = '0;
            rcnt  = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            wa    = w && (sz < DEPTH);
            ra    = r && (sz > 0);
            ovf_n = w && (sz == DEPTH);
            udf_n = r && (sz == 0);
            if (ra) begin void'(m_q.pop_front()); rcnt = rcnt + 1'b1; end
            if (wa) begin m_q.push_back(int'(wcnt[AW-1:0])); wcnt = wcnt + 1'b1; end
            m_ovf = ovf_n;
            m_udf = udf_n;
        end
        m_prev_rst = rs;
        @(posedge clk);
        #1;
    endtask

    // monitor: compare on the falling edge, away from the active edge
    exp_t        e_m;
    logic [AW:0] prev_wg, prev_rg;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e_m = sb.pop_front();
            chk("wr_ack",    bus.wr_ack,    e_m.wr_ack);
            chk("rd_ack",    bus.rd_ack,    e_m.rd_ack);
            chk("wr_addr",   bus.wr_addr,   e_m.wr_addr);
            chk("rd_addr",   bus.rd_addr,   e_m.rd_addr);
            chk("wptr_gray", bus.wptr_gray, e_m.wgray);
            chk("rptr_gray", bus.rptr_gray, e_m.rgray);
            chk("count",     bus.count,     e_m.count);
            chk("full",      bus.full,      e_m.full);
            chk("empty",     bus.empty,     e_m.empty);
            chk("ovf",       bus.ovf,       e_m.ovf);
            chk("udf",       bus.udf,       e_m.udf);
            chk("g2b_wr",    g2b(bus.wptr_gray) & 5'hF, 32'(bus.wr_addr));
            if (e_m.gchk) begin
                if (bus.wptr_gray != prev_wg)
                    chk("wgray_1bit", $countones(bus.wptr_gray ^ prev_wg), 1);
                if (bus.rptr_gray != prev_rg)
                    chk("rgray_1bit", $countones(bus.rptr_gray ^ prev_rg), 1);
            end
            prev_wg = bus.wptr_gray;
            prev_rg = bus.rptr_gray;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        @(posedge clk);
        #1;
        // 1. reset held two cycles with both requests high
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 1);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full",  bus.full,  0);
        chk("rst_wgray", bus.wptr_gray, 0);
        // 2. fill, then one write while full
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 1);
        chk("fill_count", bus.count, 16);
        chk("fill_full",  bus.full,  1);
        cycle(1, 0, 0, 1);
        chk("ovf_pulse",  bus.ovf,     1);
        chk("ovf_waddr",  bus.wr_addr, 0);
        cycle(0, 0, 0, 1);
        chk("ovf_clear",  bus.ovf, 0);
        // 3. drain, then one read while empty
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 1);
        chk("drain_count", bus.count, 0);
        chk("drain_empty", bus.empty, 1);
        cycle(0, 1, 0, 1);
        chk("udf_pulse",   bus.udf, 1);
        cycle(0, 0, 0, 1);
        // 4. 40 gated write/read pairs: pointers wrap through 31 -> 0
        for (int i = 0; i < 40; i++) begin
            if (m_q.size() < DEPTH) cycle(1, 0, 0, 1);
            if (m_q.size() > 0)     cycle(0, 1, 0, 1);
        end
        // 5. simultaneous requests at mid, full and empty
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1);
        chk("sim_mid_count", bus.count, 5);
        for (int i = 0; i < 11; i++) cycle(1, 0, 0, 1);
        chk("sim_full", bus.full, 1);
        cycle(1, 1, 0, 1);
        chk("sim_full_count", bus.count, 15);
        chk("sim_full_ovf",   bus.ovf,   1);
        for (int i = 0; i < 15; i++) cycle(0, 1, 0, 1);
        chk("sim_empty", bus.empty, 1);
        cycle(1, 1, 0, 1);
        chk("sim_empty_count", bus.count, 1);
        chk("sim_empty_udf",   bus.udf,   1);
        // 6. random traffic with a mid-run reset
        for (int i = 0; i < 2000; i++)
            cycle(1'($urandom_range(1)), 1'($urandom_range(1)), i == 1000, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
